// File: rtl/front_panel_pkg.sv
// Shared types and constants for the front-panel LED driver and its helpers.
package front_panel_pkg;

   localparam int LED_COUNT    = 8;
   localparam int PWM_BITS_DEF = 4;

   typedef logic [LED_COUNT-1:0] led_vec_t;

   // Spread one control bit across every LED lane.
   function automatic led_vec_t led_fill(input logic b);
      return {LED_COUNT{b}};
   endfunction

endpackage

// File: rtl/strobe_sync.sv
// Brings an asynchronous strobe into the CLK domain through a flop chain.
// It emits a registered one-cycle pulse on each rising edge of the strobe.
// The pulse appears SYNC_STAGES+1 CLK edges after the strobe is first sampled high.
module strobe_sync
   import front_panel_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic NRST,
   input  logic STB_IN,
   output logic STB_RISE
);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   sync_last_p1;
   logic                   rise_p2;

   // Metastability chain, previous-value flop and registered rising-edge pulse
   always_ff @(posedge CLK or posedge NRST) begin
      if (NRST) begin
         sync_p0      <= '0;
         sync_last_p1 <= 1'b0;
         rise_p2      <= 1'b0;
      end else begin
         sync_p0      <= {sync_p0[SYNC_STAGES-2:0], STB_IN};
         sync_last_p1 <= sync_p0[SYNC_STAGES-1];
         rise_p2      <= sync_p0[SYNC_STAGES-1] & ~sync_last_p1;
      end
   end

   assign STB_RISE = rise_p2;

endmodule

// File: rtl/front_panel_led_driver.sv
// Front-panel LED driver.
// An 8-bit LED image arrives from the SPI slave (SCLK domain) with a strobe.
// The strobe is synchronized, and the image is captured into a shadow register.
// The image is committed to the active register only at a PWM period boundary,
// so a visible PWM cycle never mixes two images.
// The outputs add global PWM dimming, per-LED blink and a lamp-test override.
module front_panel_led_driver
   import front_panel_pkg::*;
#(
   parameter int PWM_BITS    = PWM_BITS_DEF,
   parameter int BLINK_HALF  = 6000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                CLK,
   input  logic                NRST,
   input  led_vec_t            LED_DATA,
   input  logic                LED_STB,
   input  logic [PWM_BITS-1:0] BRIGHT,
   input  led_vec_t            BLINK_EN,
   input  logic                LAMP_TEST,
   output led_vec_t            LED_OUT,
   output logic                UPDATED,
   output logic                UPD_LOST
);

   localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
   localparam int                  BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

   logic                cap;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                wrap;
   logic                pwm_on;
   logic [BLINK_W-1:0]  blink_cnt;
   logic                blink_phase;

   led_vec_t            shadow_p0;
   logic                pending_p0;
   led_vec_t            active_p1;
   logic                upd_lost_q;
   logic                updated_p2;
   led_vec_t            led_out_p2;

   led_vec_t            shadow_nxt;
   logic                pending_nxt;
   led_vec_t            active_nxt;
   logic                upd_lost_nxt;
   logic                commit;
   led_vec_t            led_out_nxt;

   // Strobe from the SCLK domain becomes a single CLK-domain capture pulse
   strobe_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_strobe_sync (
      .CLK      (CLK),
      .NRST     (NRST),
      .STB_IN   (LED_STB),
      .STB_RISE (cap)
   );

   assign wrap   = (pwm_cnt == PWM_MAX);
   assign pwm_on = (BRIGHT == PWM_MAX) || (pwm_cnt < BRIGHT);

   // Free-running PWM counter; its last count marks the commit boundary
   always_ff @(posedge CLK or posedge NRST) begin
      if (NRST) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // Blink prescaler: phase toggles every BLINK_HALF clocks
   always_ff @(posedge CLK or posedge NRST) begin
      if (NRST) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
   end

   // Capture and commit decisions.
   // A capture that lands on the wrap goes straight to active.
   // A second capture while one is still pending overwrites it and flags the loss.
   always_comb begin
      shadow_nxt   = shadow_p0;
      pending_nxt  = pending_p0;
      active_nxt   = active_p1;
      upd_lost_nxt = upd_lost_q;
      commit       = 1'b0;
      if (cap) begin
         shadow_nxt = LED_DATA;
         if (wrap) begin
            active_nxt  = LED_DATA;
            pending_nxt = 1'b0;
            commit      = 1'b1;
         end else begin
            pending_nxt = 1'b1;
            if (pending_p0) begin
               upd_lost_nxt = 1'b1;
            end
         end
      end else if (wrap && pending_p0) begin
         active_nxt  = shadow_p0;
         pending_nxt = 1'b0;
         commit      = 1'b1;
      end
   end

   // Shadow/pending (capture stage), active image (commit stage) and the loss flag
   always_ff @(posedge CLK or posedge NRST) begin
      if (NRST) begin
         shadow_p0  <= '0;
         pending_p0 <= 1'b0;
         active_p1  <= '0;
         upd_lost_q <= 1'b0;
      end else begin
         shadow_p0  <= shadow_nxt;
         pending_p0 <= pending_nxt;
         active_p1  <= active_nxt;
         upd_lost_q <= upd_lost_nxt;
      end
   end

   // Output combine: lamp test wins, otherwise image gated by blink and PWM
   always_comb begin
      led_out_nxt = '0;
      if (LAMP_TEST) begin
         led_out_nxt = led_fill(1'b1);
      end else begin
         led_out_nxt = active_p1 & (~BLINK_EN | led_fill(blink_phase)) & led_fill(pwm_on);
      end
   end

   // Registered LED drive and the commit pulse
   always_ff @(posedge CLK or posedge NRST) begin
      if (NRST) begin
         led_out_p2 <= '0;
         updated_p2 <= 1'b0;
      end else begin
         led_out_p2 <= led_out_nxt;
         updated_p2 <= commit;
      end
   end

   assign LED_OUT  = led_out_p2;
   assign UPDATED  = updated_p2;
   assign UPD_LOST = upd_lost_q;

endmodule

// File: tb/tb_front_panel_led_driver.sv
// Testbench for front_panel_led_driver.
// A cycle-level reference model derived from elapsed clock counts checks every output on each falling edge.
// Directed scenarios add literal expectations, followed by a randomized phase.
module tb_front_panel_led_driver;

   localparam int PB     = 2;
   localparam int BH     = 4;
   localparam int SS     = 2;
   localparam int PERIOD = 1 << PB;
   localparam int PMAX   = PERIOD - 1;

   logic          CLK = 1'b0;
   logic          NRST = 1'b1;
   logic [7:0]    LED_DATA = 8'h00;
   logic          LED_STB = 1'b0;
   logic [PB-1:0] BRIGHT = 2'd3;
   logic [7:0]    BLINK_EN = 8'h00;
   logic          LAMP_TEST = 1'b0;
   logic [7:0]    LED_OUT;
   logic          UPDATED;
   logic          UPD_LOST;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   front_panel_led_driver #(
      .PWM_BITS    (PB),
      .BLINK_HALF  (BH),
      .SYNC_STAGES (SS)
   ) dut (
      .CLK       (CLK),
      .NRST      (NRST),
      .LED_DATA  (LED_DATA),
      .LED_STB   (LED_STB),
      .BRIGHT    (BRIGHT),
      .BLINK_EN  (BLINK_EN),
      .LAMP_TEST (LAMP_TEST),
      .LED_OUT   (LED_OUT),
      .UPDATED   (UPDATED),
      .UPD_LOST  (UPD_LOST)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model.
   // t counts clocks since reset. The PWM position is t mod PERIOD and the blink phase is (t / BH) parity.
   // A capture happens SS+1 edges after the strobe is first sampled high.
   int         t         = 0;
   bit [3:0]   hist      = '0;
   logic [7:0] m_shadow  = 8'h00;
   logic [7:0] m_active  = 8'h00;
   bit         m_pending = 1'b0;
   bit         m_lost    = 1'b0;
   bit         m_upd     = 1'b0;
   logic [7:0] m_led     = 8'h00;

   always @(posedge CLK or posedge NRST) begin : model
      bit         cap, wrap, on, phase, nu;
      logic [7:0] nl;
      if (NRST) begin
         t = 0; hist = '0; m_shadow = 8'h00; m_active = 8'h00;
         m_pending = 1'b0; m_lost = 1'b0; m_upd = 1'b0; m_led = 8'h00;
      end else begin
         cap   = hist[SS] && !hist[SS+1];
         wrap  = (t % PERIOD) == PMAX;
         on    = (int'(BRIGHT) == PMAX) || ((t % PERIOD) < int'(BRIGHT));
         phase = ((t / BH) % 2) == 0;
         nl    = LAMP_TEST ? 8'hFF
                 : (m_active & (~BLINK_EN | (phase ? 8'hFF : 8'h00)) & (on ? 8'hFF : 8'h00));
         nu    = 1'b0;
         if (cap && wrap) begin
            m_shadow = LED_DATA; m_active = LED_DATA; m_pending = 1'b0; nu = 1'b1;
         end else if (cap) begin
            if (m_pending) m_lost = 1'b1;
            m_shadow = LED_DATA; m_pending = 1'b1;
         end else if (wrap && m_pending) begin
            m_active = m_shadow; m_pending = 1'b0; nu = 1'b1;
         end
         hist  = {hist[2:0], LED_STB};
         t++;
         m_led = nl;
         m_upd = nu;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge CLK) begin
      check("led_out", {24'h0, LED_OUT}, {24'h0, m_led});
      check("updated", {31'h0, UPDATED}, {31'h0, m_upd});
      check("upd_lost", {31'h0, UPD_LOST}, {31'h0, m_lost});
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Wait until the next edge sees PWM position k
   task automatic wait_phase(input int k);
      int guard = 0;
      while ((t % PERIOD) != k && guard < 2 * PERIOD) begin
         tick();
         guard++;
      end
   endtask

   task automatic strobe_at(input logic [7:0] d, input int k);
      wait_phase(k);
      LED_DATA = d;
      LED_STB  = 1'b1;
      repeat (3) tick();
      LED_STB  = 1'b0;
      repeat (8) tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cnt, first, c_ff, c_00, c_b0, c_rest;
      repeat (3) @(posedge CLK);
      #1 NRST = 1'b0;

      // 1: idle after reset
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (UPDATED) cnt++;
      end
      check("t1_led", {24'h0, LED_OUT}, 32'h00);
      check("t1_upd_cnt", cnt, 0);
      check("t1_lost", {31'h0, UPD_LOST}, 32'h0);

      // 2: single image, commit at the following wrap
      wait_phase(1);
      LED_DATA = 8'hA5;
      LED_STB  = 1'b1;
      cnt = 0; first = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 3) LED_STB = 1'b0;
         if (UPDATED) begin
            cnt++;
            if (first == 0) first = i;
         end
      end
      check("t2_upd_at", first, 7);
      check("t2_upd_cnt", cnt, 1);
      check("t2_led", {24'h0, LED_OUT}, 32'hA5);

      // 3: PWM dimming
      strobe_at(8'hFF, 1);
      BRIGHT = 2'd1;
      repeat (2) tick();
      c_ff = 0; c_00 = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (LED_OUT == 8'hFF) c_ff++;
         if (LED_OUT == 8'h00) c_00++;
      end
      check("t3_on_cnt", c_ff, 2);
      check("t3_off_cnt", c_00, 6);
      BRIGHT = 2'd0;
      repeat (2) tick();
      c_ff = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (LED_OUT != 8'h00) c_ff++;
      end
      check("t3_dark_cnt", c_ff, 0);

      // 4: blink on bit 0 and lamp test
      BRIGHT = 2'd3;
      strobe_at(8'h0F, 1);
      BLINK_EN = 8'h01;
      repeat (2) tick();
      c_b0 = 0; c_rest = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (LED_OUT[0]) c_b0++;
         if (LED_OUT[7:1] == 7'b0000111) c_rest++;
      end
      check("t4_blink_cnt", c_b0, 8);
      check("t4_steady_cnt", c_rest, 16);
      LAMP_TEST = 1'b1;
      tick();
      check("t4_lamp", {24'h0, LED_OUT}, 32'hFF);
      LAMP_TEST = 1'b0;
      BLINK_EN  = 8'h00;
      repeat (2) tick();

      // 5a: capture coincides with wrap, so the image bypasses the shadow
      wait_phase(0);
      LED_DATA = 8'h5A;
      LED_STB  = 1'b1;
      repeat (3) tick();
      LED_STB  = 1'b0;
      check("t5_bypass_early", {31'h0, UPDATED}, 32'h0);
      tick();
      check("t5_bypass_upd", {31'h0, UPDATED}, 32'h1);
      repeat (2) tick();
      check("t5_bypass_led", {24'h0, LED_OUT}, 32'h5A);
      check("t5_bypass_lost", {31'h0, UPD_LOST}, 32'h0);
      repeat (4) tick();

      // 5b: two captures inside one PWM period (pulses closer than the normal contract)
      wait_phase(1);
      LED_DATA = 8'h11;
      LED_STB  = 1'b1;
      tick();
      LED_STB  = 1'b0;
      tick();
      LED_STB  = 1'b1;
      tick();
      tick();
      LED_DATA = 8'h22;
      LED_STB  = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (UPDATED) cnt++;
      end
      check("t5_lost_upd_cnt", cnt, 1);
      check("t5_lost_flag", {31'h0, UPD_LOST}, 32'h1);
      check("t5_lost_led", {24'h0, LED_OUT}, 32'h22);

      // 6: reset with an image pending
      strobe_at(8'hFF, 1);
      check("t6_pre_led", {24'h0, LED_OUT}, 32'hFF);
      wait_phase(1);
      LED_DATA = 8'h00;
      LED_STB  = 1'b1;
      repeat (3) tick();
      LED_STB  = 1'b0;
      tick();
      #1 NRST = 1'b1;
      #1;
      check("t6_rst_led", {24'h0, LED_OUT}, 32'h00);
      check("t6_rst_lost", {31'h0, UPD_LOST}, 32'h0);
      repeat (2) tick();
      NRST = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (UPDATED) cnt++;
      end
      check("t6_no_upd", cnt, 0);
      check("t6_led_dark", {24'h0, LED_OUT}, 32'h00);

      // Randomized traffic against the model
      for (int i = 0; i < 250; i++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r < 9) begin
            LED_DATA = 8'($urandom);
            LED_STB  = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            LED_STB  = 1'b0;
            repeat ($urandom_range(1, 5)) tick();
         end else if (r < 13) begin
            BRIGHT = 2'($urandom_range(0, 3));
            tick();
         end else if (r < 17) begin
            BLINK_EN = 8'($urandom);
            tick();
         end else if (r < 19) begin
            LAMP_TEST = ($urandom_range(0, 3) == 0);
            tick();
         end else begin
            #2 NRST = 1'b1;
            tick();
            NRST = 1'b0;
            tick();
         end
      end
      LAMP_TEST = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
